// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants for the instruction fetch/execute sequencer
//
// Purpose: state encoding, instruction field positions and instruction-class
// helpers used by cpu_sequencer.
package cpu_pkg;

  // FSM state encoding (plain constants, legacy-compatible 3-bit encoding)
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_MREAD  = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MWRITE = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  // Instruction field positions
  localparam int A_BIT   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_HI = 5;
  localparam int DEST_LO = 3;
  localparam int JMP_HI  = 2;
  localparam int JMP_LO  = 0;

  // Top three bits of every legal C-instruction
  localparam logic [2:0] C_PREFIX = 3'b111;

  function automatic logic is_c_instr(input logic [15:0] ir);
    return ir[15:13] == C_PREFIX;
  endfunction

  // Bit 15 set but not the full C prefix: no defined meaning
  function automatic logic is_illegal(input logic [15:0] ir);
    return ir[15] && (ir[14:13] != 2'b11);
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/memory/execute sequencer
//
// Purpose: steps one instruction at a time through FETCH, DECODE, optional
// MREAD, EXEC, optional MWRITE, and commits register writes and the PC
// update in exactly one cycle per instruction. Optional HALT single-step
// is enabled by defining CPU_SEQ_STEP_EN.
//
// Ports:
//   i_clk, i_rst                     clock, asynchronous active-high reset
//   o_imem_req/o_imem_addr           instruction fetch request, address = PC
//   i_imem_ack/i_imem_data           fetch completion and instruction word
//   o_instr                          instruction register to the control unit
//   i_a_we/i_d_we/i_m_we             decoded write strobes from the control unit
//   i_pc_we/i_pc                     jump taken and jump target
//   o_a_we/o_d_we                    write enables, asserted only in commit cycle
//   o_dmem_req/o_dmem_we             data request, 1 = write, 0 = read
//   i_dmem_ack/i_dmem_rdata          data completion and read data
//   o_m                              latched memory read value
//   o_pc                             current PC
//   i_halt/o_halted                  halt request and HALT status
//   o_illegal                        one-cycle pulse on illegal instruction commit
//   i_step (CPU_SEQ_STEP_EN only)    rising edge in HALT runs one instruction
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [15:0] i_imem_data,
  output logic [15:0] o_instr,
  input  logic        i_a_we,
  input  logic        i_d_we,
  input  logic        i_m_we,
  input  logic        i_pc_we,
  input  logic [15:0] i_pc,
  output logic        o_a_we,
  output logic        o_d_we,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  input  logic        i_dmem_ack,
  input  logic [15:0] i_dmem_rdata,
  output logic [15:0] o_m,
  output logic [15:0] o_pc,
  input  logic        i_halt,
`ifdef CPU_SEQ_STEP_EN
  input  logic        i_step,
`endif
  output logic        o_halted,
  output logic        o_illegal
);
  import cpu_pkg::*;

  logic [2:0]  state;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [15:0] m_q;
  logic        ill;
  logic        commit;
  logic        halt_next;

  assign ill = is_illegal(ir);

  // An illegal instruction never enters MWRITE, so it commits in EXEC.
  // A write commits in the MWRITE ack cycle so A changes only after the
  // store addressed by the old A has completed.
  always_comb begin
    commit = 1'b0;
    if (state == ST_EXEC)
      commit = !(i_m_we && !ill);
    else if (state == ST_MWRITE)
      commit = i_dmem_ack;
  end

`ifdef CPU_SEQ_STEP_EN
  logic step_q;
  logic step_mode;
  logic step_rise;
  assign step_rise = i_step && !step_q;
  assign halt_next = i_halt || step_mode;
`else
  assign halt_next = i_halt;
`endif

  // State is FETCH during reset; gate the request so it drops immediately.
  assign o_imem_req  = (state == ST_FETCH) && !i_rst;
  assign o_imem_addr = pc;
  assign o_pc        = pc;
  assign o_instr     = ir;
  assign o_m         = m_q;
  assign o_dmem_req  = (state == ST_MREAD) || (state == ST_MWRITE);
  assign o_dmem_we   = (state == ST_MWRITE);
  assign o_a_we      = commit && !ill && i_a_we;
  assign o_d_we      = commit && !ill && i_d_we;
  assign o_illegal   = commit && ill;
  assign o_halted    = (state == ST_HALT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
      ir    <= 16'h0000;
      m_q   <= 16'h0000;
    end else begin
      case (state)
        ST_FETCH: begin
          if (i_imem_ack) begin
            ir    <= i_imem_data;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          state <= (is_c_instr(ir) && ir[A_BIT]) ? ST_MREAD : ST_EXEC;
        end
        ST_MREAD: begin
          if (i_dmem_ack) begin
            m_q   <= i_dmem_rdata;
            state <= ST_EXEC;
          end
        end
        ST_EXEC, ST_MWRITE: begin
          if (commit) begin
            pc    <= (i_pc_we && !ill) ? i_pc : pc + 16'd1;
            state <= halt_next ? ST_HALT : ST_FETCH;
          end else if (state == ST_EXEC) begin
            state <= ST_MWRITE;
          end
        end
        ST_HALT: begin
`ifdef CPU_SEQ_STEP_EN
          if (step_rise || !i_halt) state <= ST_FETCH;
`else
          if (!i_halt) state <= ST_FETCH;
`endif
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

`ifdef CPU_SEQ_STEP_EN
  // step_mode forces a return to HALT after the stepped instruction commits
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      step_q    <= 1'b0;
      step_mode <= 1'b0;
    end else begin
      step_q <= i_step;
      if (state == ST_HALT && step_rise)
        step_mode <= 1'b1;
      else if (commit)
        step_mode <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - randomized self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

  localparam logic [15:0] RST_PC = 16'hFFFE;

  logic        i_clk, i_rst;
  logic        o_imem_req;
  logic [15:0] o_imem_addr;
  logic        i_imem_ack;
  logic [15:0] i_imem_data;
  logic [15:0] o_instr;
  logic        i_a_we, i_d_we, i_m_we, i_pc_we;
  logic [15:0] i_pc;
  logic        o_a_we, o_d_we, o_dmem_req, o_dmem_we;
  logic        i_dmem_ack;
  logic [15:0] i_dmem_rdata;
  logic [15:0] o_m, o_pc;
  logic        i_halt, o_halted, o_illegal;
`ifdef CPU_SEQ_STEP_EN
  logic        i_step;
`endif

  cpu_sequencer #(.RESET_PC(RST_PC)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
    .o_instr(o_instr),
    .i_a_we(i_a_we), .i_d_we(i_d_we), .i_m_we(i_m_we),
    .i_pc_we(i_pc_we), .i_pc(i_pc),
    .o_a_we(o_a_we), .o_d_we(o_d_we),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_m(o_m), .o_pc(o_pc),
    .i_halt(i_halt),
`ifdef CPU_SEQ_STEP_EN
    .i_step(i_step),
`endif
    .o_halted(o_halted), .o_illegal(o_illegal)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model state (architectural view only)
  logic [15:0] m_pc, m_ir, m_m;
  // Expected outputs for the current cycle
  logic        chk_en;
  logic        e_ireq, e_dreq, e_dwe, e_awe, e_dstb, e_ill, e_halted;
  logic [15:0] e_pc, e_instr, e_m;
  logic        force_mid_halt;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: every cycle, away from the active edge
  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("imem_req",  16'(o_imem_req), 16'(e_ireq));
      chk("imem_addr", o_imem_addr, e_pc);
      chk("pc",        o_pc, e_pc);
      chk("dmem_req",  16'(o_dmem_req), 16'(e_dreq));
      if (e_dreq) chk("dmem_we", 16'(o_dmem_we), 16'(e_dwe));
      chk("a_we",      16'(o_a_we), 16'(e_awe));
      chk("d_we",      16'(o_d_we), 16'(e_dstb));
      chk("illegal",   16'(o_illegal), 16'(e_ill));
      chk("halted",    16'(o_halted), 16'(e_halted));
      chk("instr",     o_instr, e_instr);
      chk("m",         o_m, e_m);
    end
  end

  // One instruction as a schedule: fetch waits fd cycles, read waits rdd,
  // write waits wrd; commit is the last cycle. Then hc halt cycles if hlt.
  task automatic run_instr(input logic [15:0] instr, input logic a, input logic d,
                           input logic mw, input logic pw, input logic [15:0] tgt,
                           input int fd, input int rdd, input int wrd,
                           input logic hlt, input int hc, input logic [15:0] rdata,
                           output int ncyc);
    logic ill, rd, wr, in_rd, in_wr;
    int ex, cm;
    ill = instr[15] && (instr[14:13] != 2'b11);
    rd  = (instr[15:13] == 3'b111) && instr[12];
    wr  = !ill && mw;
    ex  = fd + 2 + (rd ? rdd + 1 : 0);
    cm  = wr ? ex + 1 + wrd : ex;
    for (int k = 0; k <= cm; k++) begin
      in_rd = rd && (k >= fd + 2) && (k <= fd + 2 + rdd);
      in_wr = wr && (k > ex) && (k <= cm);
      i_imem_ack   = (k == fd) ? 1'b1 : ((k > fd) ? 1'($urandom_range(0, 1)) : 1'b0);
      i_imem_data  = (k == fd) ? instr : 16'($urandom);
      if (in_rd)      i_dmem_ack = (k == fd + 2 + rdd);
      else if (in_wr) i_dmem_ack = (k == cm);
      else            i_dmem_ack = 1'($urandom_range(0, 1));
      i_dmem_rdata = (in_rd && k == fd + 2 + rdd) ? rdata : 16'($urandom);
      i_a_we = a; i_d_we = d; i_m_we = mw; i_pc_we = pw; i_pc = tgt;
      i_halt = (k == cm) ? hlt : (force_mid_halt ? 1'b1 : 1'($urandom_range(0, 1)));
      e_ireq = (k <= fd);
      e_dreq = in_rd || in_wr;
      e_dwe  = in_wr;
      e_awe  = (k == cm) && a && !ill;
      e_dstb = (k == cm) && d && !ill;
      e_ill  = (k == cm) && ill;
      e_halted = 1'b0;
      e_pc = m_pc; e_instr = m_ir; e_m = m_m;
      @(posedge i_clk); #1;
      if (k == fd) m_ir = instr;
      if (rd && k == fd + 2 + rdd) m_m = rdata;
      if (k == cm) m_pc = (ill || !pw) ? m_pc + 16'd1 : tgt;
    end
    ncyc = cm + 1;
    if (hlt) begin
      for (int h = 0; h < hc; h++) begin
        i_halt = (h < hc - 1);
        i_imem_ack = 1'($urandom_range(0, 1));
        i_dmem_ack = 1'($urandom_range(0, 1));
        i_a_we = 1'($urandom_range(0, 1)); i_d_we = 1'($urandom_range(0, 1));
        i_m_we = 1'($urandom_range(0, 1)); i_pc_we = 1'($urandom_range(0, 1));
        e_ireq = 0; e_dreq = 0; e_dwe = 0; e_awe = 0; e_dstb = 0; e_ill = 0;
        e_halted = 1'b1;
        e_pc = m_pc; e_instr = m_ir; e_m = m_m;
        @(posedge i_clk); #1;
      end
    end
  endtask

  task automatic run_random(input int n);
    logic [15:0] instr;
    logic mw;
    int cat, nc;
    for (int i = 0; i < n; i++) begin
      cat = $urandom_range(0, 3);
      case (cat)
        0:       instr = {1'b0, 15'($urandom)};
        1:       instr = {4'b1111, 12'($urandom)};
        2:       instr = {4'b1110, 12'($urandom)};
        default: instr = {1'b1, 2'($urandom_range(0, 2)), 13'($urandom)};
      endcase
      mw = (cat == 1 || cat == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_instr(instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mw,
                1'($urandom_range(0, 1)), 16'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                ($urandom_range(0, 7) == 0), $urandom_range(1, 3), 16'($urandom), nc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int nc;
    force_mid_halt = 0;
    i_rst = 1; i_imem_ack = 0; i_imem_data = 0; i_a_we = 0; i_d_we = 0; i_m_we = 0;
    i_pc_we = 0; i_pc = 0; i_dmem_ack = 0; i_dmem_rdata = 0; i_halt = 0;
`ifdef CPU_SEQ_STEP_EN
    i_step = 0;
`endif
    m_pc = RST_PC; m_ir = 0; m_m = 0;
    e_ireq = 0; e_dreq = 0; e_dwe = 0; e_awe = 0; e_dstb = 0; e_ill = 0; e_halted = 0;
    e_pc = RST_PC; e_instr = 0; e_m = 0;
    chk_en = 1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_pc", o_pc, 16'hFFFE);
    chk("rst_instr", o_instr, 16'h0000);
    chk("rst_m", o_m, 16'h0000);
    chk("rst_imem_req", 16'(o_imem_req), 16'h0000);
    i_rst = 0;

    // A-instruction, immediate ack
    run_instr(16'h0005, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, nc);
    chk("lat_a", 16'(nc), 16'd3);
    chk("pc_a", o_pc, 16'hFFFF);
    // D=M, 2-cycle read delay, PC wraps from FFFF
    run_instr(16'hFC10, 0, 1, 0, 0, 16'h0000, 0, 2, 0, 0, 1, 16'h1234, nc);
    chk("lat_rd", 16'(nc), 16'd6);
    chk("m_rd", o_m, 16'h1234);
    chk("pc_wrap", o_pc, 16'h0000);
    // AM=D+1, write commits before A strobe
    run_instr(16'hEDE8, 1, 0, 1, 0, 16'h0000, 0, 0, 1, 0, 1, 16'h0000, nc);
    chk("lat_wr", 16'(nc), 16'd5);
    chk("pc_wr", o_pc, 16'h0001);
    // 0;JMP
    run_instr(16'hEA87, 0, 0, 0, 1, 16'h0100, 0, 0, 0, 0, 1, 16'h0000, nc);
    chk("lat_jmp", 16'(nc), 16'd3);
    chk("pc_jmp", o_pc, 16'h0100);
    // Halt held high throughout an M read: instruction completes first
    force_mid_halt = 1;
    run_instr(16'hFC10, 0, 1, 0, 0, 16'h0000, 1, 1, 0, 1, 3, 16'hBEEF, nc);
    force_mid_halt = 0;
    chk("pc_halt", o_pc, 16'h0101);
    chk("m_halt", o_m, 16'hBEEF);

    run_random(150);

    // Reset in the middle of MWRITE; a late ack must not commit
    chk_en = 0;
    i_imem_ack = 1; i_imem_data = 16'hE308; i_a_we = 1; i_d_we = 1; i_m_we = 1;
    i_pc_we = 0; i_dmem_ack = 0; i_halt = 0;
    @(posedge i_clk); #1;
    i_imem_ack = 0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("mw_dmem_req", 16'(o_dmem_req), 16'h0001);
    chk("mw_dmem_we", 16'(o_dmem_we), 16'h0001);
    i_rst = 1;
    #1;
    chk("rst_mw_dmem_req", 16'(o_dmem_req), 16'h0000);
    chk("rst_mw_pc", o_pc, 16'hFFFE);
    chk("rst_mw_a_we", 16'(o_a_we), 16'h0000);
    @(posedge i_clk); #1;
    i_rst = 0;
    i_dmem_ack = 1;
    #1;
    chk("late_ack_a_we", 16'(o_a_we), 16'h0000);
    chk("late_ack_d_we", 16'(o_d_we), 16'h0000);
    chk("late_ack_imem_req", 16'(o_imem_req), 16'h0001);
    @(posedge i_clk); #1;
    chk("late_ack_pc", o_pc, 16'hFFFE);
    chk("late_ack_instr", o_instr, 16'h0000);
    chk("late_ack_m", o_m, 16'h0000);
    i_dmem_ack = 0;
    m_pc = RST_PC; m_ir = 0; m_m = 0;
    chk_en = 1;
    run_random(20);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  in  1  asynchronous, active-high reset.
REQ-004 o_imem_req  out  1  instruction fetch request; o_imem_addr  out  16  fetch address (= PC).
REQ-005 i_imem_ack  in  1  fetch complete; i_imem_data  in  16  instruction word, valid with ack.
REQ-006 o_instr  out  16  instruction register (IR) driven to the control unit.
REQ-007 i_a_we, i_d_we, i_m_we  in  1 each  decoded write strobes from the control unit.
REQ-008 i_pc_we  in  1  jump taken; i_pc  in  16  jump target.
REQ-009 o_a_we, o_d_we  out  1 each  commit-gated register write enables.
REQ-010 o_dmem_req  out  1  data request; o_dmem_we  out  1  1 = write, 0 = read; i_dmem_ack  in  1  data complete; i_dmem_rdata  in  16.
REQ-011 o_m  out  16  latched memory read value for the control unit M input.
REQ-012 o_pc  out  16  current PC; i_halt  in  1  halt request; o_halted  out  1  in HALT state; o_illegal  out  1  one-cycle pulse.

Function
REQ-013 FSM states SHALL be FETCH, DECODE, MREAD, EXEC, MWRITE, HALT.
REQ-014 FETCH: o_imem_req=1 and o_imem_addr=PC held until i_imem_ack; on ack IR<=i_imem_data, then DECODE.
REQ-015 DECODE: C-instr (IR[15:13]=111) with IR[12]=1 -> MREAD; otherwise -> EXEC.
REQ-016 MREAD: o_dmem_req=1, o_dmem_we=0 until i_dmem_ack; on ack o_m<=i_dmem_rdata, then EXEC.
REQ-017 EXEC: if i_m_we=1 -> MWRITE without committing; otherwise commit this cycle.
REQ-018 MWRITE: o_dmem_req=1, o_dmem_we=1 until i_dmem_ack; commit in the ack cycle.
REQ-019 Commit (one cycle): o_a_we=i_a_we, o_d_we=i_d_we; PC<=i_pc_we ? i_pc : PC+1 (16-bit, 16'hFFFF wraps to 0).
REQ-020 o_a_we/o_d_we SHALL be 0 in every non-commit cycle, so A is not updated before an M write addressed by the old A.
REQ-021 Instruction with IR[15]=1 and IR[14:13]!=11 is illegal: no strobes, PC+1, o_illegal pulses in the commit cycle.
REQ-022 i_halt sampled in the commit cycle: 1 -> HALT; else -> FETCH; halt is never taken mid-instruction.
REQ-023 HALT: o_halted=1, no requests; i_halt=0 -> FETCH next cycle.
REQ-024 Latency without stalls: A-instr 3 cycles, C-instr with M read 4, with M write 4, read and write 5.
REQ-025 Requests SHALL remain asserted and stable until the matching ack; an ack with no request is ignored.

Reset
REQ-026 While i_rst=1: PC=RESET_PC, IR=0, o_m=0, state FETCH, and all request/strobe/status outputs 0, immediately (asynchronously).
REQ-027 Reset asserted mid-transaction drops the request at once; the outstanding access is abandoned and later acks are ignored.
REQ-028 First fetch request is asserted in the first clock after i_rst deasserts.

Configuration
REQ-029 Macro CPU_SEQ_STEP_EN defined: extra port i_step (in, 1); a rising i_step in HALT executes exactly one instruction, then returns to HALT regardless of i_halt.
REQ-030 CPU_SEQ_STEP_EN undefined: no i_step port, and HALT exits only through i_halt=0.

Structure
REQ-031 Package cpu_pkg SHALL hold the state enumeration, instruction field positions (A-bit 12, comp 11:6, dest 5:3, jmp 2:0), and the C-instr prefix constant 3'b111.
REQ-032 Single module; no sub-module. PC increment and FSM stay inline.

Verification
REQ-033 Reset, then ack immediately; fetch 16'h0005 -> PC 0->1, o_a_we=0 (A write is owned by the control unit), 3 cycles per instruction.
REQ-034 C-instr D=M (16'hFC10) with rdata 16'h1234 and 2-cycle ack delay -> o_m=16'h1234, o_d_we pulses once, PC+1.
REQ-035 AM=D+1 (16'hEDE8) -> MWRITE completes before o_a_we pulses; memory address observed = old A.
REQ-036 0;JMP (16'hEA87) with i_pc=16'h0100, i_pc_we=1 -> PC=16'h0100; at PC=16'hFFFF with no jump -> PC=0.
REQ-037 i_halt raised mid-MREAD -> the instruction completes, then o_halted=1; with CPU_SEQ_STEP_EN, one i_step pulse -> exactly one PC advance.
REQ-038 i_rst pulsed during MWRITE -> o_dmem_req=0 immediately, PC=RESET_PC, and a late ack causes no commit.
